// File: rtl/gs_acq_sequencer.sv
// gs_acq_sequencer: command-driven strided burst reader streaming raw samples to a TX FIFO
module gs_acq_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 8,
  parameter int NUM_CH = 4
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic [31:0]       i32Cmd_Data,
  input  logic              iCmd_Empty,
  output logic              oCmd_Rd,
  output logic [ADDR_W-1:0] oAddr,
  output logic [SEL_W-1:0]  oSignSelec,
  input  logic [DATA_W-1:0] iReg,
  output logic              oWriteRawSignal,
  output logic [DATA_W-1:0] oRawSignal,
  input  logic              iTxFull,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
);
  typedef enum logic [1:0] {IDLE, DECODE, RUN} state_t;
  state_t state, state_nx;
  logic [31:0] cmd;
  logic [7:0] remaining;
  logic [3:0] op;
  logic sel_bad, burst, burst_ok, head_abort, capture, last;
  assign op = cmd[31:28];
  assign sel_bad = int'(cmd[27:24]) >= NUM_CH;
  assign burst = state == DECODE && op == 4'h1 && !sel_bad;
  assign burst_ok = burst && cmd[15:8] != 8'd0;
  assign head_abort = !iCmd_Empty && i32Cmd_Data[31:28] == 4'h2;
  assign capture = state == RUN && !head_abort && !iTxFull;
  assign last = remaining == 8'd1;
  assign oBusy = burst_ok || state == RUN;
  // Next state and pop strobe; no pop while the done pulse is out so the next command starts a cycle later
  always_comb begin
    state_nx = state;
    oCmd_Rd = 1'b0;
    case (state)
      IDLE: begin
        oCmd_Rd = iReset && !iCmd_Empty && !oDone;
        state_nx = oCmd_Rd ? DECODE : IDLE;
      end
      DECODE: state_nx = burst_ok ? RUN : IDLE;
      RUN: begin
        oCmd_Rd = head_abort;
        state_nx = (head_abort || (capture && last)) ? IDLE : RUN;
      end
      default: state_nx = IDLE;
    endcase
  end
  // State, command latch, burst address/count, sample capture and sticky error
  always_ff @(posedge iClk or negedge iReset)
    if (!iReset) begin
      state <= IDLE;
      cmd <= '0;
      remaining <= '0;
      oAddr <= '0;
      oSignSelec <= '0;
      oWriteRawSignal <= 1'b0;
      oRawSignal <= '0;
      oDone <= 1'b0;
      oErr <= 1'b0;
    end else begin
      state <= state_nx;
      oWriteRawSignal <= capture;
      oDone <= (burst && !burst_ok) || (capture && last);
      if (state == IDLE && oCmd_Rd) cmd <= i32Cmd_Data;
      if (burst_ok) begin
        oAddr <= cmd[16 +: ADDR_W];
        remaining <= cmd[15:8];
        oSignSelec <= SEL_W'(cmd[27:24]);
      end
      if (capture) begin
        oRawSignal <= iReg;
        oAddr <= oAddr + cmd[0 +: ADDR_W];
        remaining <= remaining - 8'd1;
      end
      if (state == DECODE && op == 4'h3) oErr <= 1'b0;
      if (state == DECODE && (op > 4'h3 || (op == 4'h1 && sel_bad))) oErr <= 1'b1;
    end
endmodule

// File: tb/tb_gs_acq_sequencer.sv
// tb_gs_acq_sequencer: scenario and randomized checks against a burst-level reference model
module tb_gs_acq_sequencer;
  logic iClk = 1'b0, iReset = 1'b0;
  logic [31:0] i32Cmd_Data = '0;
  logic iCmd_Empty = 1'b1, iTxFull = 1'b0;
  logic oCmd_Rd, oWriteRawSignal, oBusy, oDone, oErr;
  logic [7:0] oAddr, oSignSelec;
  logic [15:0] iReg, oRawSignal;
  logic [31:0] fifo[$];
  logic [15:0] exp_q[$], wr_d[$];
  int wr_c[$], done_c[$], pop_c[$];
  int cyc = 0, total = 0, bad = 0, empty_pops = 0;

  gs_acq_sequencer dut (
    .iClk(iClk), .iReset(iReset), .i32Cmd_Data(i32Cmd_Data), .iCmd_Empty(iCmd_Empty),
    .oCmd_Rd(oCmd_Rd), .oAddr(oAddr), .oSignSelec(oSignSelec), .iReg(iReg),
    .oWriteRawSignal(oWriteRawSignal), .oRawSignal(oRawSignal), .iTxFull(iTxFull),
    .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
  );

  always #5 iClk = ~iClk;
  // Raw-signal source: every (select, address) pair yields a distinct word
  assign iReg = {oSignSelec[3:0], 4'h5, oAddr};

  // Record TX writes and done pulses with their cycle number
  always @(negedge iClk)
    if (iReset) begin
      if (oWriteRawSignal) begin
        wr_d.push_back(oRawSignal);
        wr_c.push_back(cyc);
      end
      if (oDone) done_c.push_back(cyc);
    end

  task automatic tick(input logic full);
    logic rd;
    @(negedge iClk);
    iTxFull = full;
    iCmd_Empty = fifo.size() == 0;
    i32Cmd_Data = iCmd_Empty ? 32'h0 : fifo[0];
    #1;
    rd = oCmd_Rd;
    if (rd && iCmd_Empty) empty_pops++;
    @(posedge iClk);
    if (rd && fifo.size() != 0) begin
      void'(fifo.pop_front());
      pop_c.push_back(cyc);
    end
    cyc++;
    #1;
  endtask

  task automatic clear();
    fifo.delete(); exp_q.delete(); wr_d.delete(); wr_c.delete(); done_c.delete(); pop_c.delete();
    empty_pops = 0;
  endtask

  // Expected sample stream of one burst command: sel, start, count, stride with 8-bit address wrap
  task automatic build_exp(input logic [31:0] c);
    logic [7:0] a;
    a = c[23:16];
    for (int i = 0; i < int'(c[15:8]); i++) begin
      exp_q.push_back({c[27:24], 4'h5, a});
      a = a + c[7:0];
    end
  endtask

  task automatic test_reset();
    iReset = 1'b0;
    iCmd_Empty = 1'b0;
    i32Cmd_Data = 32'h11000401;
    repeat (3) @(negedge iClk);
    #1;
    total++;
    if ({oCmd_Rd, oAddr, oSignSelec, oWriteRawSignal, oRawSignal, oBusy, oDone, oErr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got rd=%b addr=%h sel=%h wr=%b data=%h busy=%b done=%b err=%b exp all zero",
               oCmd_Rd, oAddr, oSignSelec, oWriteRawSignal, oRawSignal, oBusy, oDone, oErr);
    end
    iCmd_Empty = 1'b1;
    @(negedge iClk);
    iReset = 1'b1;
    @(posedge iClk);
    #1;
  endtask

  task automatic test_basic();
    int t0, n;
    clear();
    fifo.push_back(32'h11000401);
    build_exp(32'h11000401);
    t0 = cyc;
    repeat (12) tick(1'b0);
    total++;
    if (pop_c.size() != 1 || pop_c[0] != t0) begin
      bad++; $display("FAIL basic_pop got n=%0d exp pop at %0d", pop_c.size(), t0);
    end
    total++;
    if (wr_d.size() != 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", wr_d.size()); end
    n = wr_d.size() < 4 ? wr_d.size() : 4;
    for (int i = 0; i < n; i++) begin
      total++;
      if (wr_d[i] !== exp_q[i] || wr_c[i] != t0 + 3 + i) begin
        bad++;
        $display("FAIL basic_write%0d got=%h@%0d exp=%h@%0d", i, wr_d[i], wr_c[i], exp_q[i], t0 + 3 + i);
      end
    end
    total++;
    if (done_c.size() != 1 || done_c[0] != t0 + 6) begin
      bad++; $display("FAIL basic_done got n=%0d exp one pulse at %0d", done_c.size(), t0 + 6);
    end
    total++;
    if (oBusy !== 1'b0 || oErr !== 1'b0) begin
      bad++; $display("FAIL basic_idle got busy=%b err=%b exp 0 0", oBusy, oErr);
    end
  endtask

  task automatic test_wrap();
    clear();
    fifo.push_back(32'h10FE0401);
    build_exp(32'h10FE0401);
    repeat (12) tick(1'b0);
    total++;
    if (wr_d.size() != 4) begin bad++; $display("FAIL wrap_count got=%0d exp=4", wr_d.size()); end
    for (int i = 0; i < 4 && i < wr_d.size(); i++) begin
      total++;
      if (wr_d[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_data%0d got=%h exp=%h", i, wr_d[i], exp_q[i]); end
    end
    total++;
    if (oAddr !== 8'h02 || oSignSelec !== 8'h00) begin
      bad++; $display("FAIL wrap_hold got addr=%h sel=%h exp 02 00", oAddr, oSignSelec);
    end
  endtask

  task automatic test_backpressure();
    int t0;
    clear();
    fifo.push_back(32'h12100803);
    build_exp(32'h12100803);
    t0 = cyc;
    for (int i = 0; i < 20; i++) tick(i >= 5 && i < 8);
    total++;
    if (wr_d.size() != 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", wr_d.size()); end
    for (int i = 0; i < 8 && i < wr_d.size(); i++) begin
      total++;
      if (wr_d[i] !== exp_q[i]) begin bad++; $display("FAIL bp_data%0d got=%h exp=%h", i, wr_d[i], exp_q[i]); end
    end
    total++;
    if (done_c.size() != 1 || done_c[0] != t0 + 13) begin
      bad++; $display("FAIL bp_done got n=%0d exp one pulse at %0d", done_c.size(), t0 + 13);
    end
  endtask

  task automatic test_abort();
    int k, n1;
    clear();
    fifo.push_back(32'h1300C801);
    build_exp(32'h1300C801);
    build_exp(32'h11400203);
    k = 0;
    while (wr_d.size() < 10 && k < 60) begin
      tick(1'b0);
      k++;
    end
    total++;
    if (k >= 60) begin bad++; $display("FAIL abort_wait got writes=%0d exp 10 within 60 cycles", wr_d.size()); end
    fifo.push_back(32'h2ABCDEF0);
    fifo.push_back(32'h11400203);
    repeat (20) tick(1'b0);
    n1 = wr_d.size() - 2;
    total++;
    if (pop_c.size() != 3 || fifo.size() != 0) begin
      bad++; $display("FAIL abort_pops got=%0d left=%0d exp 3 0", pop_c.size(), fifo.size());
    end
    total++;
    if (n1 < 10 || n1 > 11) begin bad++; $display("FAIL abort_count got=%0d exp 10..11", n1); end
    for (int i = 0; i < n1 && i < 200; i++) begin
      total++;
      if (wr_d[i] !== exp_q[i]) begin bad++; $display("FAIL abort_data%0d got=%h exp=%h", i, wr_d[i], exp_q[i]); end
    end
    for (int j = 0; j < 2 && n1 >= 0; j++) begin
      total++;
      if (wr_d[n1 + j] !== exp_q[200 + j]) begin
        bad++; $display("FAIL abort_next%0d got=%h exp=%h", j, wr_d[n1 + j], exp_q[200 + j]);
      end
    end
    total++;
    if (done_c.size() != 1 || oBusy !== 1'b0) begin
      bad++; $display("FAIL abort_done got n=%0d busy=%b exp 1 0", done_c.size(), oBusy);
    end
  endtask

  task automatic test_errors();
    logic [31:0] ec [0:6] = '{32'h17000401, 32'h30000000, 32'h90000000, 32'h00000000,
                              32'h2F000000, 32'h30000000, 32'h11200003};
    logic ee [0:6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    clear();
    for (int i = 0; i < 7; i++) begin
      fifo.push_back(ec[i]);
      repeat (6) tick(1'b0);
      total++;
      if (oErr !== ee[i]) begin bad++; $display("FAIL err_step%0d cmd=%h got=%b exp=%b", i, ec[i], oErr, ee[i]); end
    end
    total++;
    if (wr_d.size() != 0 || done_c.size() != 1 || pop_c.size() != 7) begin
      bad++; $display("FAIL err_side got writes=%0d dones=%0d pops=%0d exp 0 1 7", wr_d.size(), done_c.size(), pop_c.size());
    end
  endtask

  task automatic test_random();
    int nb, k;
    logic [31:0] c, r;
    clear();
    nb = 0;
    for (int i = 0; i < 24; i++) begin
      r = $urandom;
      if (r[31:29] == 3'd0) fifo.push_back({4'h0, r[27:0]});
      else begin
        c = {4'h1, 2'b00, r[1:0], r[15:8], 8'($urandom_range(1, 12)), r[23:16]};
        fifo.push_back(c);
        build_exp(c);
        nb++;
      end
    end
    k = 0;
    while ((fifo.size() != 0 || oBusy) && k < 3000) begin
      tick($urandom_range(0, 2) == 0);
      k++;
    end
    repeat (4) tick(1'b0);
    total++;
    if (k >= 3000) begin bad++; $display("FAIL rand_timeout got left=%0d exp 0", fifo.size()); end
    total++;
    if (wr_d.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", wr_d.size(), exp_q.size()); end
    for (int i = 0; i < wr_d.size() && i < exp_q.size(); i++) begin
      total++;
      if (wr_d[i] !== exp_q[i]) begin bad++; $display("FAIL rand_data%0d got=%h exp=%h", i, wr_d[i], exp_q[i]); end
    end
    total++;
    if (done_c.size() != nb || empty_pops != 0) begin
      bad++; $display("FAIL rand_done got dones=%0d empty_pops=%0d exp %0d 0", done_c.size(), empty_pops, nb);
    end
  endtask

  task automatic test_reset_mid();
    clear();
    fifo.push_back(32'h12003201);
    repeat (10) tick(1'b0);
    @(negedge iClk);
    #2;
    iReset = 1'b0;
    #1;
    total++;
    if ({oCmd_Rd, oAddr, oSignSelec, oWriteRawSignal, oRawSignal, oBusy, oDone, oErr} !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs got addr=%h sel=%h wr=%b data=%h busy=%b done=%b exp all zero",
               oAddr, oSignSelec, oWriteRawSignal, oRawSignal, oBusy, oDone);
    end
    repeat (2) @(negedge iClk);
    iReset = 1'b1;
    clear();
    repeat (10) tick(1'b0);
    total++;
    if (wr_d.size() != 0 || oBusy !== 1'b0) begin
      bad++; $display("FAIL rstmid_quiet got writes=%0d busy=%b exp 0 0", wr_d.size(), oBusy);
    end
    fifo.push_back(32'h11000201);
    build_exp(32'h11000201);
    repeat (8) tick(1'b0);
    total++;
    if (wr_d.size() != 2 || wr_d[0] !== exp_q[0] || wr_d[1] !== exp_q[1]) begin
      bad++; $display("FAIL rstmid_resume got writes=%0d exp 2 matching samples", wr_d.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_abort();
    test_errors();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gs_acq_sequencer.md
# gs_acq_sequencer

Command-driven raw-signal acquisition sequencer, next generation of the GS state machine. Pops 32-bit commands from the host-to-FPGA command FIFO, performs strided burst reads from a selectable raw-signal source, and streams samples into the FPGA-to-host FIFO with backpressure. Adds parametrised data, address and channel widths, burst length, stride, abort and sticky error reporting.

## Interface
- DATA_W, 16, raw sample width
- ADDR_W, 8, raw-signal address width (max 8)
- SEL_W, 8, signal-select width (min 4)
- NUM_CH, 4, number of valid signal sources; select values >= NUM_CH are illegal
- iClk  in  1  clock, all logic on rising edge
- iReset  in  1  asynchronous active-low reset
- i32Cmd_Data  in  32  command word at FIFO head (show-ahead FIFO)
- iCmd_Empty  in  1  command FIFO empty
- oCmd_Rd  out  1  pop strobe, one cycle per consumed command
- oAddr  out  ADDR_W  raw-signal read address
- oSignSelec  out  SEL_W  raw-signal source select
- iReg  in  DATA_W  raw-signal read data, combinational from oAddr/oSignSelec
- oWriteRawSignal  out  1  TX FIFO write strobe
- oRawSignal  out  DATA_W  TX FIFO write data
- iTxFull  in  1  TX FIFO almost-full (asserted with >= 2 free entries)
- oBusy  out  1  burst in progress
- oDone  out  1  one-cycle pulse on normal burst completion
- oErr  out  1  sticky error flag

## Operation
- Command format: [31:28] op, [27:24] sel, [23:16] start address, [15:8] count, [7:0] stride.
- Ops: 0x0 NOP; 0x1 BURST; 0x2 ABORT; 0x3 CLEAR_ERR; others illegal.
- States: IDLE, DECODE, RUN.
- IDLE: if iCmd_Empty=0, assert oCmd_Rd, latch command, go DECODE; else stay.
- DECODE: NOP/ABORT -> IDLE, no effect. CLEAR_ERR -> oErr=0, IDLE. Illegal op or sel >= NUM_CH -> oErr=1, IDLE. BURST with count 0 -> pulse oDone, IDLE. BURST count N>=1 -> load addr=start, remaining=N, oSignSelec=sel, go RUN.
- RUN, per cycle, priority order:
  1. iCmd_Empty=0 and head op=ABORT: pop it (oCmd_Rd=1), no capture, IDLE, no oDone.
  2. iTxFull=1: hold address and count, no capture.
  3. Else capture iReg into oRawSignal, set oWriteRawSignal next cycle, addr <= addr + stride (mod 2^ADDR_W, wraps), remaining-1; if last, pulse oDone and go IDLE.
- Non-ABORT commands at FIFO head are not popped during RUN.
- oSignSelec holds last loaded value outside RUN; oAddr holds last value.
- Stride 0 legal: N reads of the same address.
- oBusy = 1 in DECODE (BURST, N>=1) and RUN.

## Timing
- Reset: all outputs 0, state IDLE, oErr cleared. Reset mid-burst aborts immediately, no further writes.
- Command popped at cycle T (oCmd_Rd=1), DECODE T+1, first capture T+2, first oWriteRawSignal T+3.
- No backpressure: oWriteRawSignal high T+3..T+2+N contiguous; oDone high at T+2+N together with the last write; IDLE at T+3+N, next pop possible then.
- Each iTxFull cycle in RUN delays all later captures by one cycle; no sample lost or duplicated.
- oCmd_Rd never asserted when iCmd_Empty=1; at most one pop per cycle.
- ABORT at cycle of last capture: ABORT wins, last sample not written, no oDone.

## Test plan
- Reset low, FIFO with 0x1_1_00_04_01 -> pop at T, writes at T+3..T+6 from addrs 0,1,2,3 sel 1, oDone at T+6.
- Cmd 0x1_0_FE_04_01 -> addresses FE,FF,00,01 (wrap), 4 writes.
- Burst N=8 with iTxFull high 3 cycles mid-burst -> exactly 8 writes, correct ordered data, completion delayed 3 cycles.
- Burst N=200, push 0x2xxxxxxx after 10 writes -> ABORT popped, at most 11 writes, no oDone, oBusy=0, next command then served.
- Cmd 0x1_7_... (sel >= NUM_CH) and op 0x9 -> oErr=1, no writes; then 0x3 -> oErr=0.
- Assert reset during burst -> outputs 0 asynchronously, no writes after release until new command.
